// File: rtl/alu_ctrl_exec_if.sv
// alu_ctrl_exec_if: request/response bundle for the EX-stage ALU unit.
//   master (requester / pipeline side): drives start, ALUOp, function_field,
//     operand_a, operand_b; receives ready, result_valid, result, hi, zero,
//     error, ALUCtrl.
//   slave (alu_ctrl_exec): the mirror image.
// WIDTH must match the WIDTH of the alu_ctrl_exec instance it connects to.
interface alu_ctrl_exec_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [1:0]       ALUOp;
  logic [5:0]       function_field;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             ready;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             error;
  logic [3:0]       ALUCtrl;

  modport master (
    output start, ALUOp, function_field, operand_a, operand_b,
    input  ready, result_valid, result, hi, zero, error, ALUCtrl
  );

  modport slave (
    input  start, ALUOp, function_field, operand_a, operand_b,
    output ready, result_valid, result, hi, zero, error, ALUCtrl
  );
endinterface

// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: ALU control decoder plus multi-cycle execute unit.
// Decodes ALUOp/function_field into a 4-bit ALUCtrl code, then executes it on
// WIDTH-bit operands. Logic/arith ops take one EXEC cycle; MULTU (shift-add)
// and DIVU (restoring) iterate one bit per cycle for WIDTH cycles, then pass
// through EXEC, which forms the final outputs for every op.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; discards any in-flight op
//   bus    alu_ctrl_exec_if.slave: start/ready handshake, opcode fields,
//          operands, result/hi/zero/error/ALUCtrl with a result_valid pulse
module alu_ctrl_exec #(
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  alu_ctrl_exec_if.slave bus
);

  localparam logic [3:0] C_AND   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_ADD   = 4'b0010;
  localparam logic [3:0] C_XOR   = 4'b0011;
  localparam logic [3:0] C_SUB   = 4'b0110;
  localparam logic [3:0] C_SLT   = 4'b0111;
  localparam logic [3:0] C_MULTU = 4'b1000;
  localparam logic [3:0] C_DIVU  = 4'b1001;
  localparam logic [3:0] C_NOR   = 4'b1100;
  localparam logic [3:0] C_EFUNC = 4'b1110;
  localparam logic [3:0] C_EOP   = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] hi_work, lo_work;  // {acc,multiplier} or {remainder,quotient}
  logic [CNT_W-1:0] cnt;
  logic             div0;
  logic [3:0]       ctrl;
  logic             ready, result_valid, zero, error;
  logic [WIDTH-1:0] result, hi;

  // Decode of the live request fields, used only in the accept cycle.
  logic [3:0] dec;
  always_comb begin
    dec = C_EFUNC;
    case (bus.ALUOp)
      2'b00: dec = C_ADD;
      2'b01: dec = C_SUB;
      2'b11: dec = C_EOP;
      default: begin
        case (bus.function_field)
          6'b000000: dec = C_ADD;
          6'b000010: dec = C_SUB;
          6'b000100: dec = C_AND;
          6'b000101: dec = C_OR;
          6'b000110: dec = C_XOR;
          6'b000111: dec = C_NOR;
          6'b001010: dec = C_SLT;
          6'b011001: dec = C_MULTU;
          6'b011011: dec = C_DIVU;
          default:   dec = C_EFUNC;
        endcase
      end
    endcase
  end

  // One shift-add / restoring-divide step on the working pair.
  logic [WIDTH:0] mul_sum, div_shift, div_trial;
  always_comb begin
    mul_sum   = {1'b0, hi_work} + (lo_work[0] ? {1'b0, op_a} : '0);
    div_shift = {hi_work, lo_work[WIDTH-1]};
    div_trial = div_shift - {1'b0, op_b};
  end

  // Final output values formed in EXEC.
  logic [WIDTH-1:0] exec_res, exec_hi;
  logic             exec_err;
  always_comb begin
    exec_res = '0;
    exec_hi  = '0;
    exec_err = 1'b0;
    case (ctrl)
      C_ADD:   exec_res = op_a + op_b;
      C_SUB:   exec_res = op_a - op_b;
      C_AND:   exec_res = op_a & op_b;
      C_OR:    exec_res = op_a | op_b;
      C_XOR:   exec_res = op_a ^ op_b;
      C_NOR:   exec_res = ~(op_a | op_b);
      C_SLT:   exec_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      C_MULTU, C_DIVU: begin
        exec_res = lo_work;
        exec_hi  = hi_work;
      end
      default: exec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op_a         <= '0;
      op_b         <= '0;
      hi_work      <= '0;
      lo_work      <= '0;
      cnt          <= '0;
      div0         <= 1'b0;
      ctrl         <= 4'b0000;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      result       <= '0;
      hi           <= '0;
      zero         <= 1'b0;
      error        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a  <= bus.operand_a;
            op_b  <= bus.operand_b;
            ctrl  <= dec;
            cnt   <= '0;
            ready <= 1'b0;
            div0  <= 1'b0;
            if (dec == C_MULTU) begin
              hi_work <= '0;
              lo_work <= bus.operand_b;
              state   <= ITER;
            end else if (dec == C_DIVU) begin
              hi_work <= '0;
              lo_work <= bus.operand_a;
              div0    <= (bus.operand_b == '0);
              state   <= ITER;
            end else begin
              state <= EXEC;
            end
          end
        end
        ITER: begin
          cnt <= cnt + CNT_W'(1);
          if (ctrl == C_MULTU) begin
            hi_work <= mul_sum[WIDTH:1];
            lo_work <= {mul_sum[0], lo_work[WIDTH-1:1]};
          end else if (div0) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            hi_work <= op_a;
            lo_work <= '1;
          end else if (!div_trial[WIDTH]) begin
            hi_work <= div_trial[WIDTH-1:0];
            lo_work <= {lo_work[WIDTH-2:0], 1'b1};
          end else begin
            hi_work <= div_shift[WIDTH-1:0];
            lo_work <= {lo_work[WIDTH-2:0], 1'b0};
          end
          if (div0 || cnt == CNT_W'(WIDTH-1))
            state <= EXEC;
        end
        EXEC: begin
          result       <= exec_res;
          hi           <= exec_hi;
          error        <= exec_err;
          zero         <= (exec_res == '0);
          result_valid <= 1'b1;
          ready        <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          // ready is already high, but a start seen here is not taken:
          // acceptance happens only from IDLE.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready        = ready;
  assign bus.result_valid = result_valid;
  assign bus.result       = result;
  assign bus.hi           = hi;
  assign bus.zero         = zero;
  assign bus.error        = error;
  assign bus.ALUCtrl      = ctrl;

endmodule
